// File: rtl/pcc_layer_seq.sv
// pcc_layer_seq: time-multiplexes one shared popcount-compare unit across a layer of binary neurons
module pcc_layer_seq #(
  parameter int NUM_NEURONS = 8,
  localparam int IDX_W = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [4:0]             wr_pos,
  input  logic [1:0]             wr_neg,
  output logic                   wr_err,
  input  logic                   start,
  output logic                   busy,
  output logic [4:0]             pcc_pos,
  output logic [1:0]             pcc_neg,
  output logic                   pcc_en,
  input  logic                   pcc_out,
  output logic [NUM_NEURONS-1:0] res_data,
  output logic                   res_valid,
  input  logic                   res_ready
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n, nxt;
  logic [4:0] rf_pos [NUM_NEURONS];
  logic [1:0] rf_neg [NUM_NEURONS];
  logic [4:0] pos_n;
  logic [1:0] neg_n;
  logic en_n, wr_ok, last;
  logic [NUM_NEURONS-1:0] data_n;
  assign wr_ok = wr_en && state == IDLE && 32'(wr_idx) < NUM_NEURONS;
  assign last = 32'(idx) == NUM_NEURONS - 1;
  assign nxt = idx + 1'b1;
  assign busy = state != IDLE;
  assign res_valid = state == HOLD;
  // Operand register file: writes land only while idle and in range, survive evaluations
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        rf_pos[i] <= '0;
        rf_neg[i] <= '0;
      end
    end else if (wr_ok) begin
      rf_pos[wr_idx] <= wr_pos;
      rf_neg[wr_idx] <= wr_neg;
    end
  // Rejected writes (busy or out of range) report one cycle later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_err <= 1'b0;
    else wr_err <= wr_en && !wr_ok;
  // Sequencer state and registered pcc operands / result word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pcc_pos <= '0;
      pcc_neg <= '0;
      pcc_en <= 1'b0;
      res_data <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      pcc_pos <= pos_n;
      pcc_neg <= neg_n;
      pcc_en <= en_n;
      res_data <= data_n;
    end
  // Next state: a same-cycle write to entry 0 is forwarded so start sees the new operands
  always_comb begin
    state_n = state;
    idx_n = idx;
    pos_n = pcc_pos;
    neg_n = pcc_neg;
    en_n = pcc_en;
    data_n = res_data;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        idx_n = '0;
        en_n = 1'b1;
        data_n = '0;
        pos_n = wr_ok && wr_idx == '0 ? wr_pos : rf_pos[0];
        neg_n = wr_ok && wr_idx == '0 ? wr_neg : rf_neg[0];
      end
      RUN: begin
        data_n[idx] = pcc_out;
        idx_n = last ? idx : nxt;
        state_n = last ? HOLD : RUN;
        en_n = !last;
        pos_n = last ? '0 : rf_pos[nxt];
        neg_n = last ? '0 : rf_neg[nxt];
      end
      HOLD: state_n = res_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pcc_layer_seq.sv
// tb_pcc_layer_seq: randomized self-checking bench for pcc_layer_seq at 4, 5 and 64 neurons
module tb_pcc_layer_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_vec = 0, n_err = 0;
  logic [5:0] wr_idx = '0;
  logic [4:0] wr_pos = '0;
  logic [1:0] wr_neg = '0;
  logic res_ready = 1'b0;
  logic wr_en_a = 0, start_a = 0, wr_err_a, busy_a, pcc_en_a, pcc_out_a, res_valid_a;
  logic [4:0] pcc_pos_a;
  logic [1:0] pcc_neg_a;
  logic [3:0] res_data_a;
  logic wr_en_b = 0, start_b = 0, wr_err_b, busy_b, pcc_en_b, pcc_out_b, res_valid_b;
  logic [4:0] pcc_pos_b;
  logic [1:0] pcc_neg_b;
  logic [63:0] res_data_b;
  logic wr_en_c = 0, start_c = 0, wr_err_c, busy_c, pcc_en_c, pcc_out_c, res_valid_c;
  logic [4:0] pcc_pos_c;
  logic [1:0] pcc_neg_c;
  logic [4:0] res_data_c;
  assign pcc_out_a = $countones(pcc_pos_a) >= $countones(pcc_neg_a);
  assign pcc_out_b = $countones(pcc_pos_b) >= $countones(pcc_neg_b);
  assign pcc_out_c = $countones(pcc_pos_c) >= $countones(pcc_neg_c);
  pcc_layer_seq #(.NUM_NEURONS(4)) dut_a (.clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_idx(wr_idx[1:0]),
    .wr_pos(wr_pos), .wr_neg(wr_neg), .wr_err(wr_err_a), .start(start_a), .busy(busy_a), .pcc_pos(pcc_pos_a),
    .pcc_neg(pcc_neg_a), .pcc_en(pcc_en_a), .pcc_out(pcc_out_a), .res_data(res_data_a), .res_valid(res_valid_a),
    .res_ready(res_ready));
  pcc_layer_seq #(.NUM_NEURONS(64)) dut_b (.clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_idx(wr_idx),
    .wr_pos(wr_pos), .wr_neg(wr_neg), .wr_err(wr_err_b), .start(start_b), .busy(busy_b), .pcc_pos(pcc_pos_b),
    .pcc_neg(pcc_neg_b), .pcc_en(pcc_en_b), .pcc_out(pcc_out_b), .res_data(res_data_b), .res_valid(res_valid_b),
    .res_ready(res_ready));
  pcc_layer_seq #(.NUM_NEURONS(5)) dut_c (.clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_idx(wr_idx[2:0]),
    .wr_pos(wr_pos), .wr_neg(wr_neg), .wr_err(wr_err_c), .start(start_c), .busy(busy_c), .pcc_pos(pcc_pos_c),
    .pcc_neg(pcc_neg_c), .pcc_en(pcc_en_c), .pcc_out(pcc_out_c), .res_data(res_data_c), .res_valid(res_valid_c),
    .res_ready(res_ready));
  logic [4:0] mp_a [4];
  logic [1:0] mn_a [4];
  logic [4:0] mp_b [64];
  logic [1:0] mn_b [64];
  function automatic logic [3:0] exp_a();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = $countones(mp_a[i]) >= $countones(mn_a[i]);
    return r;
  endfunction
  function automatic logic [63:0] exp_b();
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = $countones(mp_b[i]) >= $countones(mn_b[i]);
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int w, input int i, input logic [4:0] p, input logic [1:0] n);
    wr_idx = 6'(i); wr_pos = p; wr_neg = n;
    wr_en_a = w == 0; wr_en_b = w == 1; wr_en_c = w == 2;
    tick();
    wr_en_a = 0; wr_en_b = 0; wr_en_c = 0;
    if (w == 0) begin mp_a[i] = p; mn_a[i] = n; end
    if (w == 1) begin mp_b[i] = p; mn_b[i] = n; end
  endtask
  task automatic start_wait_a(output int vk);
    int en;
    start_a = 1; tick(); start_a = 0; wr_en_a = 0;
    vk = -1; en = 0;
    for (int k = 0; k < 40 && vk < 0; k++) begin
      if (pcc_en_a) begin
        en++;
        if (k < 4) begin
          n_vec++;
          if ({pcc_pos_a, pcc_neg_a} !== {mp_a[k], mn_a[k]}) begin
            n_err++; $display("FAIL operands_%0d got %h expected %h", k, {pcc_pos_a, pcc_neg_a}, {mp_a[k], mn_a[k]});
          end
        end
      end
      if (res_valid_a) vk = k; else tick();
    end
    n_vec++;
    if (vk != 4 || en != 4) begin
      n_err++; $display("FAIL latency_a valid_at %0d en_cycles %0d expected 4 and 4", vk, en);
    end
  endtask
  task automatic test_reset();
    #1;
    n_vec++;
    if ({busy_a, pcc_en_a, pcc_pos_a, pcc_neg_a, res_data_a, res_valid_a, wr_err_a} !== '0) begin
      n_err++; $display("FAIL reset_a got %b expected 0", {busy_a, pcc_en_a, pcc_pos_a, pcc_neg_a, res_data_a, res_valid_a, wr_err_a});
    end
    n_vec++;
    if ({busy_b, res_data_b, res_valid_b} !== '0) begin
      n_err++; $display("FAIL reset_b got %h expected 0", {busy_b, res_data_b, res_valid_b});
    end
    tick(); tick(); rst_n = 1; tick();
    for (int i = 0; i < 4; i++) begin mp_a[i] = 0; mn_a[i] = 0; end
    for (int i = 0; i < 64; i++) begin mp_b[i] = 0; mn_b[i] = 0; end
    res_ready = 1;
    begin
      int vk;
      start_wait_a(vk);
    end
    n_vec++;
    if (res_data_a !== 4'b1111) begin n_err++; $display("FAIL reset_rf got %b expected 1111", res_data_a); end
    tick();
  endtask
  task automatic test_basic();
    int vk;
    wr(0, 0, 5'b11111, 2'b11); wr(0, 1, 5'b00001, 2'b11); wr(0, 2, 5'b00011, 2'b11); wr(0, 3, 5'b00000, 2'b00);
    n_vec++;
    if (wr_err_a !== 1'b0) begin n_err++; $display("FAIL legal_wr_err got %b expected 0", wr_err_a); end
    res_ready = 1;
    start_wait_a(vk);
    n_vec++;
    if (res_data_a !== 4'b1101 || res_data_a !== exp_a()) begin
      n_err++; $display("FAIL basic_data got %b expected 1101", res_data_a);
    end
    tick();
    n_vec++;
    if ({busy_a, res_valid_a} !== 2'b00) begin n_err++; $display("FAIL basic_done got %b expected 00", {busy_a, res_valid_a}); end
  endtask
  task automatic test_backpressure();
    int vk;
    res_ready = 0;
    start_wait_a(vk);
    for (int k = 0; k < 10; k++) begin
      start_a = k == 3;
      tick();
      n_vec++;
      if ({res_valid_a, res_data_a} !== {1'b1, 4'b1101}) begin
        n_err++; $display("FAIL hold_%0d got %b expected 11101", k, {res_valid_a, res_data_a});
      end
    end
    start_a = 0; res_ready = 1; tick();
    n_vec++;
    if ({busy_a, res_valid_a} !== 2'b00) begin n_err++; $display("FAIL bp_release got %b expected 00", {busy_a, res_valid_a}); end
    tick();
    n_vec++;
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL bp_no_queue busy %b expected 0", busy_a); end
  endtask
  task automatic test_write_rules();
    int vk;
    res_ready = 1;
    start_a = 1; tick(); start_a = 0;
    wr_idx = 2; wr_pos = 5'b00000; wr_neg = 2'b11; wr_en_a = 1; tick(); wr_en_a = 0;
    n_vec++;
    if (wr_err_a !== 1'b1) begin n_err++; $display("FAIL busy_wr_err got %b expected 1", wr_err_a); end
    tick();
    n_vec++;
    if (wr_err_a !== 1'b0) begin n_err++; $display("FAIL wr_err_pulse got %b expected 0", wr_err_a); end
    for (int k = 0; k < 20 && busy_a; k++) tick();
    start_wait_a(vk);
    n_vec++;
    if (res_data_a !== exp_a()) begin n_err++; $display("FAIL busy_wr_dropped got %b expected %b", res_data_a, exp_a()); end
    tick();
    wr(2, 5, 5'b11111, 2'b00);
    n_vec++;
    if (wr_err_c !== 1'b1) begin n_err++; $display("FAIL range_wr_err got %b expected 1", wr_err_c); end
    wr(2, 4, 5'b11111, 2'b00);
    n_vec++;
    if (wr_err_c !== 1'b0) begin n_err++; $display("FAIL inrange_wr_err got %b expected 0", wr_err_c); end
  endtask
  task automatic test_same_cycle();
    int vk;
    wr_idx = 0; wr_pos = 5'b00000; wr_neg = 2'b11; wr_en_a = 1;
    mp_a[0] = 5'b00000; mn_a[0] = 2'b11;
    start_wait_a(vk);
    n_vec++;
    if (res_data_a[0] !== 1'b0 || res_data_a !== exp_a()) begin
      n_err++; $display("FAIL same_cycle got %b expected %b", res_data_a, exp_a());
    end
    tick();
  endtask
  task automatic test_reset_mid();
    int vk;
    start_a = 1; tick(); start_a = 0; tick(); tick();
    rst_n = 0; #1;
    n_vec++;
    if ({busy_a, pcc_en_a, pcc_pos_a, pcc_neg_a, res_data_a, res_valid_a} !== '0) begin
      n_err++; $display("FAIL reset_mid got %b expected 0", {busy_a, pcc_en_a, pcc_pos_a, pcc_neg_a, res_data_a, res_valid_a});
    end
    tick(); rst_n = 1; tick();
    for (int i = 0; i < 4; i++) begin mp_a[i] = 0; mn_a[i] = 0; end
    for (int i = 0; i < 64; i++) begin mp_b[i] = 0; mn_b[i] = 0; end
    wr(0, 3, 5'b00000, 2'b10);
    start_wait_a(vk);
    n_vec++;
    if (res_data_a !== 4'b0111 || res_data_a !== exp_a()) begin
      n_err++; $display("FAIL fresh_after_reset got %b expected 0111", res_data_a);
    end
    res_ready = 0; tick();
    rst_n = 0; #1;
    n_vec++;
    if ({res_valid_a, busy_a, res_data_a} !== '0) begin
      n_err++; $display("FAIL reset_hold got %b expected 0", {res_valid_a, busy_a, res_data_a});
    end
    tick(); rst_n = 1; res_ready = 1; tick();
    for (int i = 0; i < 4; i++) begin mp_a[i] = 0; mn_a[i] = 0; end
  endtask
  task automatic test_back_to_back();
    int s1, s2;
    bit seen_idle;
    res_ready = 1;
    for (int i = 0; i < 4; i++) wr(0, i, 5'($urandom), 2'($urandom));
    start_a = 1; tick(); s1 = cyc; s2 = -1; seen_idle = 0;
    for (int k = 0; k < 30 && s2 < 0; k++) begin
      tick();
      if (!busy_a) seen_idle = 1;
      else if (seen_idle) s2 = cyc;
    end
    start_a = 0;
    n_vec++;
    if (s2 - s1 != 6) begin n_err++; $display("FAIL b2b_period got %0d expected 6", s2 - s1); end
    for (int k = 0; k < 20 && !res_valid_a; k++) tick();
    n_vec++;
    if ({res_valid_a, res_data_a} !== {1'b1, exp_a()}) begin
      n_err++; $display("FAIL b2b_data got %b expected %b", {res_valid_a, res_data_a}, {1'b1, exp_a()});
    end
    tick();
  endtask
  task automatic test_wide();
    int vk;
    res_ready = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) wr(1, i, 5'($urandom), 2'($urandom));
      start_b = 1; tick(); start_b = 0;
      vk = -1;
      for (int k = 0; k < 100 && vk < 0; k++) if (res_valid_b) vk = k; else tick();
      n_vec++;
      if (vk != 64) begin n_err++; $display("FAIL wide_latency_%0d got %0d expected 64", r, vk); end
      n_vec++;
      if (res_data_b !== exp_b()) begin n_err++; $display("FAIL wide_data_%0d got %h expected %h", r, res_data_b, exp_b()); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_write_rules();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
